// File: rtl/rl_iteration_ctrl.sv
// rl_iteration_ctrl: run-level sequencer for the range-limited force pipeline.
// Optional READ/DRAIN watchdog is compiled in when RL_ITER_CTRL_TIMEOUT_EN is defined.
module rl_iteration_ctrl #(
  parameter int NUM_CELLS      = 64,
  parameter int NUM_FILTER     = 7,
  parameter int ITER_WIDTH     = 16,
  parameter int START_HOLD     = 50,
  parameter int DRAIN_CYCLES   = 16,
  parameter int BP_CNT_WIDTH   = 32,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             go,
  input  logic [ITER_WIDTH-1:0]            num_iter,
  output logic                             busy,
  output logic                             done,
  output logic [ITER_WIDTH-1:0]            iter_count,
  output logic                             rl_start,
  input  logic [NUM_CELLS-1:0]             reading_done,
  input  logic [NUM_CELLS-1:0]             back_pressure,
  input  logic [NUM_CELLS-1:0]             filter_buffer_empty,
  input  logic [NUM_CELLS*NUM_FILTER-1:0]  force_valid,
  output logic                             mu_start,
  input  logic                             mu_done,
  output logic [BP_CNT_WIDTH-1:0]          bp_cycles,
  output logic                             timeout
);

  localparam int HOLD_W  = $clog2(START_HOLD + 1);
  localparam int QUIET_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(START_HOLD - 1);
  localparam logic [QUIET_W-1:0] QUIET_LAST = QUIET_W'(DRAIN_CYCLES - 1);

  if (START_HOLD < 1 || DRAIN_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("rl_iteration_ctrl: START_HOLD, DRAIN_CYCLES and TIMEOUT_CYCLES must all be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_READ,
    S_DRAIN,
    S_MU
  } state_t;

  state_t                state;
  logic [ITER_WIDTH-1:0] num_iter_q;
  logic [HOLD_W-1:0]     hold_cnt;
  logic [QUIET_W-1:0]    quiet_cnt;
  logic [ITER_WIDTH-1:0] iter_next;
  logic                  all_read;
  logic                  quiet;
  logic                  any_bp;
  logic                  bp_window;
  logic                  wd_expired;
  logic                  run_accept;

  assign all_read   = &reading_done;
  assign quiet      = (&filter_buffer_empty) & ~(|force_valid);
  assign any_bp     = |back_pressure;
  assign bp_window  = (state == S_READ) || (state == S_DRAIN);
  assign iter_next  = iter_count + 1'b1;
  assign run_accept = (state == S_IDLE) && go && (num_iter != '0);

`ifdef RL_ITER_CTRL_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_cnt;

  // Counts only READ/DRAIN cycles; START and MU hold it at zero so each iteration starts fresh.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wd_cnt <= '0;
    end else if (!bp_window) begin
      wd_cnt <= '0;
    end else if (!wd_expired) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign wd_expired = bp_window && (wd_cnt == WD_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      timeout <= 1'b0;
    end else if (run_accept) begin
      timeout <= 1'b0;
    end else if (wd_expired) begin
      timeout <= 1'b1;
    end
  end
`else
  assign wd_expired = 1'b0;
  assign timeout    = 1'b0;
`endif

  // NOTE: all state here uses non-blocking assignments, so every branch reads pre-edge values
  // and later assignments in the same cycle cleanly override the per-cycle defaults above them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      iter_count <= '0;
      rl_start   <= 1'b0;
      mu_start   <= 1'b0;
      bp_cycles  <= '0;
      num_iter_q <= '0;
      hold_cnt   <= '0;
      quiet_cnt  <= '0;
    end else begin
      done     <= 1'b0;
      mu_start <= 1'b0;

      if (bp_window && any_bp && (bp_cycles != '1)) begin
        bp_cycles <= bp_cycles + 1'b1;
      end

      unique case (state)
        S_IDLE: begin
          if (go) begin
            iter_count <= '0;
            if (num_iter != '0) begin
              num_iter_q <= num_iter;
              bp_cycles  <= '0;
              hold_cnt   <= '0;
              rl_start   <= 1'b1;
              busy       <= 1'b1;
              state      <= S_START;
            end else begin
              done <= 1'b1;
            end
          end
        end

        S_START: begin
          if (hold_cnt == HOLD_LAST) begin
            rl_start <= 1'b0;
            state    <= S_READ;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end

        S_READ: begin
          if (wd_expired) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else if (all_read) begin
            quiet_cnt <= '0;
            state     <= S_DRAIN;
          end
        end

        S_DRAIN: begin
          if (wd_expired) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else if (!quiet) begin
            quiet_cnt <= '0;
          end else if (quiet_cnt == QUIET_LAST) begin
            mu_start <= 1'b1;
            state    <= S_MU;
          end else begin
            quiet_cnt <= quiet_cnt + 1'b1;
          end
        end

        S_MU: begin
          if (mu_done) begin
            iter_count <= iter_next;
            if (iter_next == num_iter_q) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_IDLE;
            end else begin
              hold_cnt <= '0;
              rl_start <= 1'b1;
              state    <= S_START;
            end
          end
        end

        default: begin
          busy     <= 1'b0;
          rl_start <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rl_iteration_ctrl.sv
// tb_rl_iteration_ctrl: timeline-based reference model for rl_iteration_ctrl runs.
// Define RL_ITER_CTRL_TIMEOUT_EN for both files to exercise the watchdog.
module tb_rl_iteration_ctrl;

  localparam int NUM_CELLS      = 4;
  localparam int NUM_FILTER     = 2;
  localparam int ITER_WIDTH     = 16;
  localparam int START_HOLD     = 4;
  localparam int DRAIN_CYCLES   = 3;
  localparam int BP_CNT_WIDTH   = 4;
  localparam int TIMEOUT_CYCLES = 20;
  localparam int FV_W           = NUM_CELLS * NUM_FILTER;
  localparam int BP_MAX         = (1 << BP_CNT_WIDTH) - 1;
  localparam int MAXC = 512;
  localparam int MAXI = 8;
  localparam int MAXD = 16;
  localparam int TAIL = 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    go;
  logic [ITER_WIDTH-1:0]   num_iter;
  logic                    busy;
  logic                    done;
  logic [ITER_WIDTH-1:0]   iter_count;
  logic                    rl_start;
  logic [NUM_CELLS-1:0]    reading_done;
  logic [NUM_CELLS-1:0]    back_pressure;
  logic [NUM_CELLS-1:0]    filter_buffer_empty;
  logic [FV_W-1:0]         force_valid;
  logic                    mu_start;
  logic                    mu_done;
  logic [BP_CNT_WIDTH-1:0] bp_cycles;
  logic                    timeout;

  always #5 clk = ~clk;

  rl_iteration_ctrl #(
    .NUM_CELLS(NUM_CELLS), .NUM_FILTER(NUM_FILTER), .ITER_WIDTH(ITER_WIDTH),
    .START_HOLD(START_HOLD), .DRAIN_CYCLES(DRAIN_CYCLES), .BP_CNT_WIDTH(BP_CNT_WIDTH),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .go(go), .num_iter(num_iter), .busy(busy), .done(done),
    .iter_count(iter_count), .rl_start(rl_start), .reading_done(reading_done),
    .back_pressure(back_pressure), .filter_buffer_empty(filter_buffer_empty),
    .force_valid(force_valid), .mu_start(mu_start), .mu_done(mu_done),
    .bp_cycles(bp_cycles), .timeout(timeout)
  );

  int vectors = 0;
  int miscompares = 0;

  // Run plan: per iteration READ latency, MU latency and DRAIN quiet pattern
  // (0 = quiet, 1 = random non-quiet, 2 = force_valid[3] only).
  int n_iter;
  int rd_lat    [MAXI];
  int mu_lat    [MAXI];
  int drain_pat [MAXI][MAXD];
  int done_cyc  [MAXI];
  int last_cycle;
  int drain_start0;
  int last_bp = 0;

  logic [NUM_CELLS-1:0] s_rdone [MAXC];
  logic [NUM_CELLS-1:0] s_bp    [MAXC];
  logic [NUM_CELLS-1:0] s_empty [MAXC];
  logic [FV_W-1:0]      s_valid [MAXC];
  logic                 s_mudone[MAXC];
  bit                   in_window[MAXC];
  bit                   e_busy[MAXC], e_done[MAXC], e_rl[MAXC], e_mu[MAXC];
  int                   e_iter[MAXC], e_bp[MAXC];

  int obs_rl, obs_mu, obs_done, obs_busy, obs_mu_cycle;

  function automatic logic [NUM_CELLS-1:0] not_all_ones();
    logic [NUM_CELLS-1:0] v;
    v = NUM_CELLS'($urandom);
    if (&v) v[$urandom_range(0, NUM_CELLS-1)] = 1'b0;
    return v;
  endfunction

  function automatic logic [FV_W-1:0] nonzero_valid();
    logic [FV_W-1:0] v;
    v = FV_W'($urandom);
    if (v == '0) v[$urandom_range(0, FV_W-1)] = 1'b1;
    return v;
  endfunction

  // Length of DRAIN: first point where DRAIN_CYCLES consecutive quiet cycles have been seen.
  function automatic int drain_len(input int i);
    int run = 0;
    for (int k = 0; k < MAXD; k++) begin
      run = (drain_pat[i][k] == 0) ? run + 1 : 0;
      if (run == DRAIN_CYCLES) return k + 1;
    end
    return MAXD;
  endfunction

  task automatic plan_fixed(input int n, input int rd, input int mu);
    n_iter = n;
    for (int i = 0; i < MAXI; i++) begin
      rd_lat[i] = rd;
      mu_lat[i] = mu;
      for (int k = 0; k < MAXD; k++) drain_pat[i][k] = 0;
    end
  endtask

  task automatic plan_random();
    int pre;
    plan_fixed($urandom_range(1, 3), 0, 0);
    for (int i = 0; i < n_iter; i++) begin
      rd_lat[i] = $urandom_range(0, 4);
      mu_lat[i] = $urandom_range(0, 3);
      pre = $urandom_range(0, 8);
      for (int k = 0; k < pre; k++) drain_pat[i][k] = ($urandom_range(0, 4) < 2) ? 1 : 0;
    end
  endtask

  task automatic build_stim(input bit bp_rand);
    int c = 1;
    int len;
    for (int d = 0; d < MAXC; d++) begin
      s_rdone[d]   = NUM_CELLS'($urandom);
      s_bp[d]      = bp_rand ? NUM_CELLS'($urandom) : '0;
      s_empty[d]   = NUM_CELLS'($urandom);
      s_valid[d]   = FV_W'($urandom);
      s_mudone[d]  = 1'($urandom);
      in_window[d] = 1'b0;
      e_rl[d]      = 1'b0;
      e_mu[d]      = 1'b0;
    end
    for (int i = 0; i < n_iter; i++) begin
      for (int k = 0; k < START_HOLD; k++) begin
        e_rl[c] = 1'b1;
        c++;
      end
      for (int k = 0; k <= rd_lat[i]; k++) begin
        in_window[c] = 1'b1;
        s_rdone[c]   = (k == rd_lat[i]) ? '1 : not_all_ones();
        c++;
      end
      if (i == 0) drain_start0 = c;
      len = drain_len(i);
      for (int k = 0; k < len; k++) begin
        in_window[c] = 1'b1;
        case (drain_pat[i][k])
          0: begin s_empty[c] = '1; s_valid[c] = '0; end
          2: begin s_empty[c] = '1; s_valid[c] = FV_W'(1) << 3; end
          default: begin
            if ($urandom_range(0, 1) == 1) begin
              s_empty[c] = not_all_ones();
              s_valid[c] = FV_W'($urandom);
            end else begin
              s_empty[c] = '1;
              s_valid[c] = nonzero_valid();
            end
          end
        endcase
        c++;
      end
      e_mu[c] = 1'b1;
      for (int k = 0; k <= mu_lat[i]; k++) begin
        s_mudone[c] = (k == mu_lat[i]);
        c++;
      end
      done_cyc[i] = c - 1;
    end
    last_cycle = c - 1;
  endtask

  task automatic compute_expect();
    int cnt = 0;
    for (int c = 0; c < MAXC; c++) begin
      e_busy[c] = (n_iter > 0) && (c >= 1) && (c <= last_cycle);
      e_done[c] = (c == last_cycle + 1);
      e_iter[c] = 0;
      for (int i = 0; i < n_iter; i++) if (done_cyc[i] < c) e_iter[c]++;
      if (n_iter == 0) begin
        e_bp[c] = last_bp;
      end else begin
        e_bp[c] = (cnt > BP_MAX) ? BP_MAX : cnt;
        if (c >= 1 && in_window[c] && (|s_bp[c])) cnt++;
      end
    end
  endtask

  // Entered and left at posedge+1 with the DUT idle; abort_at >= 0 applies reset in that cycle.
  task automatic run(input string name, input int abort_at);
    int stop = last_cycle + TAIL;
    obs_rl = 0; obs_mu = 0; obs_done = 0; obs_busy = 0; obs_mu_cycle = -1;
    for (int c = 0; c <= stop; c++) begin
      if (abort_at >= 0 && c == abort_at + 1) begin
        rst = 1'b1;
        go  = 1'b0;
        @(negedge clk);
        vectors++;
        if ({busy, done, rl_start, mu_start, timeout, iter_count, bp_cycles} !== '0) begin
          miscompares++;
          $display("FAIL %s reset_abort @%0d: got busy=%b done=%b rl=%b mu=%b to=%b iter=%0d bp=%0d, expected all 0",
                   name, c, busy, done, rl_start, mu_start, timeout, iter_count, bp_cycles);
        end
        @(posedge clk); #1;
        last_bp = 0;
        return;
      end
      rst      = !(c == abort_at);
      go       = (c == 0) ? 1'b1 : (c <= last_cycle) ? 1'($urandom) : 1'b0;
      num_iter = (c == 0) ? ITER_WIDTH'(n_iter) : ITER_WIDTH'($urandom);
      reading_done        = s_rdone[c];
      back_pressure       = s_bp[c];
      filter_buffer_empty = s_empty[c];
      force_valid         = s_valid[c];
      mu_done             = s_mudone[c];
      @(negedge clk);
      obs_rl   += int'(rl_start);
      obs_mu   += int'(mu_start);
      obs_done += int'(done);
      obs_busy += int'(busy);
      if (mu_start === 1'b1 && obs_mu_cycle < 0) obs_mu_cycle = c;
      vectors++;
      if (busy !== e_busy[c]) begin
        miscompares++;
        $display("FAIL %s busy @%0d: got %b expected %b", name, c, busy, e_busy[c]);
      end
      vectors++;
      if (done !== e_done[c]) begin
        miscompares++;
        $display("FAIL %s done @%0d: got %b expected %b", name, c, done, e_done[c]);
      end
      vectors++;
      if (rl_start !== e_rl[c]) begin
        miscompares++;
        $display("FAIL %s rl_start @%0d: got %b expected %b", name, c, rl_start, e_rl[c]);
      end
      vectors++;
      if (mu_start !== e_mu[c]) begin
        miscompares++;
        $display("FAIL %s mu_start @%0d: got %b expected %b", name, c, mu_start, e_mu[c]);
      end
      vectors++;
      if (timeout !== 1'b0) begin
        miscompares++;
        $display("FAIL %s timeout @%0d: got %b expected 0", name, c, timeout);
      end
      if (c >= 1) begin
        vectors++;
        if (iter_count !== ITER_WIDTH'(e_iter[c])) begin
          miscompares++;
          $display("FAIL %s iter_count @%0d: got %0d expected %0d", name, c, iter_count, e_iter[c]);
        end
        vectors++;
        if (bp_cycles !== BP_CNT_WIDTH'(e_bp[c])) begin
          miscompares++;
          $display("FAIL %s bp_cycles @%0d: got %0d expected %0d", name, c, bp_cycles, e_bp[c]);
        end
      end
      @(posedge clk); #1;
    end
    last_bp = e_bp[stop];
  endtask

  task automatic test_reset();
    rst = 1'b0; go = 1'b0; num_iter = '0; mu_done = 1'b0;
    reading_done = '0; back_pressure = '0; filter_buffer_empty = '0; force_valid = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({busy, done, rl_start, mu_start, timeout, iter_count, bp_cycles} !== '0) begin
      miscompares++;
      $display("FAIL reset outputs: got busy=%b done=%b rl=%b mu=%b to=%b iter=%0d bp=%0d, expected all 0",
               busy, done, rl_start, mu_start, timeout, iter_count, bp_cycles);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    last_bp = 0;
  endtask

  task automatic test_basic();
    plan_fixed(2, 5, 2);
    build_stim(1'b0);
    compute_expect();
    run("basic", -1);
    vectors++;
    if (obs_rl != 2 * START_HOLD || obs_mu != 2 || obs_done != 1) begin
      miscompares++;
      $display("FAIL basic pulse_counts: got rl=%0d mu=%0d done=%0d expected rl=%0d mu=2 done=1",
               obs_rl, obs_mu, obs_done, 2 * START_HOLD);
    end
    vectors++;
    if (iter_count !== ITER_WIDTH'(2) || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic final: got iter=%0d busy=%b expected iter=2 busy=0", iter_count, busy);
    end
  endtask

  task automatic test_zero_iter();
    plan_fixed(0, 0, 0);
    build_stim(1'b1);
    compute_expect();
    run("zero_iter", -1);
    vectors++;
    if (obs_done != 1 || obs_busy != 0 || obs_rl != 0) begin
      miscompares++;
      $display("FAIL zero_iter counts: got done=%0d busy=%0d rl=%0d expected 1/0/0", obs_done, obs_busy, obs_rl);
    end
  endtask

  task automatic test_drain_restart();
    int glitch;
    plan_fixed(1, 0, 0);
    drain_pat[0][2] = 2;
    build_stim(1'b0);
    compute_expect();
    glitch = drain_start0 + 2;
    run("drain_restart", -1);
    vectors++;
    if (obs_mu_cycle != glitch + 1 + DRAIN_CYCLES) begin
      miscompares++;
      $display("FAIL drain_restart mu_cycle: got %0d expected %0d", obs_mu_cycle, glitch + 1 + DRAIN_CYCLES);
    end
  endtask

  task automatic test_back_pressure();
    int rs = 1 + START_HOLD;
    plan_fixed(1, 8, 1);
    build_stim(1'b0);
    for (int k = 0; k < 7; k++) s_bp[rs + k] = 4'b0010;
    s_bp[last_cycle + 1] = 4'b0010;
    s_bp[last_cycle + 2] = 4'b0010;
    compute_expect();
    run("back_pressure", -1);
    vectors++;
    if (bp_cycles !== BP_CNT_WIDTH'(7)) begin
      miscompares++;
      $display("FAIL back_pressure total: got %0d expected 7", bp_cycles);
    end
    plan_random();
    build_stim(1'b1);
    compute_expect();
    run("bp_cleared_on_go", -1);
  endtask

  task automatic test_bp_saturate();
    plan_fixed(3, 4, 0);
    build_stim(1'b0);
    for (int d = 0; d < MAXC; d++) s_bp[d] = 4'b1000;
    compute_expect();
    run("bp_saturate", -1);
    vectors++;
    if (bp_cycles !== BP_CNT_WIDTH'(BP_MAX)) begin
      miscompares++;
      $display("FAIL bp_saturate final: got %0d expected %0d", bp_cycles, BP_MAX);
    end
  endtask

  task automatic test_reset_mid_run();
    plan_fixed(2, 1, 1);
    build_stim(1'b1);
    compute_expect();
    run("reset_mid_run", drain_start0 + 1);
    plan_fixed(1, 2, 1);
    build_stim(1'b1);
    compute_expect();
    run("after_reset", -1);
    vectors++;
    if (obs_done != 1 || iter_count !== ITER_WIDTH'(1)) begin
      miscompares++;
      $display("FAIL after_reset completion: got done=%0d iter=%0d expected 1/1", obs_done, iter_count);
    end
  endtask

`ifdef RL_ITER_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    int tot = START_HOLD + TIMEOUT_CYCLES;
    for (int c = 0; c <= tot + 3; c++) begin
      go = (c == 0);
      num_iter = ITER_WIDTH'(1);
      reading_done        = not_all_ones();
      back_pressure       = NUM_CELLS'($urandom);
      filter_buffer_empty = NUM_CELLS'($urandom);
      force_valid         = FV_W'($urandom);
      mu_done             = 1'($urandom);
      @(negedge clk);
      if (c >= 1) begin
        vectors++;
        if (busy !== (c <= tot) || timeout !== (c > tot)) begin
          miscompares++;
          $display("FAIL timeout busy/flag @%0d: got busy=%b timeout=%b expected busy=%b timeout=%b",
                   c, busy, timeout, c <= tot, c > tot);
        end
        vectors++;
        if (done !== 1'b0 || iter_count !== '0) begin
          miscompares++;
          $display("FAIL timeout done/iter @%0d: got done=%b iter=%0d expected 0/0", c, done, iter_count);
        end
      end
      @(posedge clk); #1;
    end
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    @(negedge clk);
    vectors++;
    if (timeout !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout relaunch: got timeout=%b busy=%b expected 0/1", timeout, busy);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    last_bp = 0;
  endtask
`else
  task automatic test_timeout();
    plan_fixed(1, 30, 0);
    build_stim(1'b1);
    compute_expect();
    run("no_watchdog", -1);
  endtask
`endif

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      plan_random();
      build_stim(1'b1);
      compute_expect();
      run($sformatf("random%0d", r), -1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_iter();
    test_drain_restart();
    test_back_pressure();
    test_bp_saturate();
    test_reset_mid_run();
    test_timeout();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
